// File: rtl/pe_pkg.sv
// Shared definitions for the int16 parallel-PE datapath and its sequencer.
// Holds datapath geometry and the controller state encoding.
package pe_pkg;

   localparam int LANES  = 32;
   localparam int DATA_W = 16;
   localparam int PROD_W = 32;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_OUT   = 3'd3;
   localparam logic [2:0] ST_FIN   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_ISSUE = ST_ISSUE,
      S_DRAIN = ST_DRAIN,
      S_OUT   = ST_OUT,
      S_FIN   = ST_FIN
   } state_t;

endpackage

// File: rtl/pe_ctrl_dly.sv
// Fixed-depth shift register that carries {rd_en, first_chunk} from the read
// issue point to the accumulator stage; synchronous clear flushes pending strobes.
module pe_ctrl_dly #(
   parameter int PIPE_LAT = 3
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] din,
   output logic [1:0] dout
);

   logic [1:0] stage [PIPE_LAT];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= din;
         for (int i = 1; i < PIPE_LAT; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[PIPE_LAT-1];

endmodule

// File: rtl/pe_mac_ctrl.sv
// Sequencer for the 32-lane int16 MAC datapath: issues NRAM/WRAM reads, strobes the
// accumulator after the read pipeline, and hands each dot product to write-back.
module pe_mac_ctrl
   import pe_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic [LEN_W-1:0]  out_num,
   input  logic [ADDR_W-1:0] nram_base,
   input  logic [ADDR_W-1:0] wram_base,
   output logic              busy,
   output logic              done,
   output logic              nram_rd_en,
   output logic [ADDR_W-1:0] nram_addr,
   output logic              wram_rd_en,
   output logic [ADDR_W-1:0] wram_addr,
   output logic              acc_en,
   output logic              acc_clr,
   output logic              result_vld,
   input  logic              result_rdy,
   output logic [LEN_W-1:0]  result_idx
);

   localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  num_q;
   logic [LEN_W-1:0]  chunk_cnt;
   logic [LEN_W-1:0]  out_cnt;
   logic [ADDR_W-1:0] nbase_q;
   logic [DRN_W-1:0]  drain_cnt;
   logic              rd_en;
   logic              first_chunk;
   logic [1:0]        dly_out;
   logic [LEN_W-1:0]  len_last;
   logic [LEN_W-1:0]  num_last;

   // Both counters stay within LEN_W: comparing against len-1 avoids overflow at vec_len=2^LEN_W-1.
   assign len_last = len_q - LEN_W'(1);
   assign num_last = num_q - LEN_W'(1);

   pe_ctrl_dly #(
      .PIPE_LAT (PIPE_LAT)
   ) u_dly (
      .clk  (clk),
      .clr  (rst),
      .din  ({rd_en, first_chunk}),
      .dout (dly_out)
   );

   assign nram_rd_en = rd_en;
   assign wram_rd_en = rd_en;
   assign acc_en     = dly_out[1];
   assign acc_clr    = dly_out[1] & dly_out[0];

   // wram_addr is itself the running pointer: rows are contiguous, so the next row
   // starts one past the last chunk read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         len_q       <= '0;
         num_q       <= '0;
         chunk_cnt   <= '0;
         out_cnt     <= '0;
         nbase_q     <= '0;
         drain_cnt   <= '0;
         rd_en       <= 1'b0;
         first_chunk <= 1'b0;
         nram_addr   <= '0;
         wram_addr   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result_vld  <= 1'b0;
         result_idx  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  len_q     <= vec_len;
                  num_q     <= out_num;
                  nbase_q   <= nram_base;
                  chunk_cnt <= '0;
                  out_cnt   <= '0;
                  if (vec_len == '0 || out_num == '0) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end else begin
                     state       <= S_ISSUE;
                     busy        <= 1'b1;
                     rd_en       <= 1'b1;
                     first_chunk <= 1'b1;
                     nram_addr   <= nram_base;
                     wram_addr   <= wram_base;
                  end
               end
            end
            S_ISSUE: begin
               first_chunk <= 1'b0;
               if (chunk_cnt == len_last) begin
                  state     <= S_DRAIN;
                  rd_en     <= 1'b0;
                  drain_cnt <= '0;
               end else begin
                  chunk_cnt <= chunk_cnt + LEN_W'(1);
                  nram_addr <= nram_addr + ADDR_W'(1);
                  wram_addr <= wram_addr + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRN_LAST) begin
                  state      <= S_OUT;
                  result_vld <= 1'b1;
                  result_idx <= out_cnt;
               end else begin
                  drain_cnt <= drain_cnt + DRN_W'(1);
               end
            end
            S_OUT: begin
               if (result_rdy) begin
                  result_vld <= 1'b0;
                  if (out_cnt == num_last) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state       <= S_ISSUE;
                     out_cnt     <= out_cnt + LEN_W'(1);
                     chunk_cnt   <= '0;
                     rd_en       <= 1'b1;
                     first_chunk <= 1'b1;
                     nram_addr   <= nbase_q;
                     wram_addr   <= wram_addr + ADDR_W'(1);
                  end
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Scoreboard bench for pe_mac_ctrl: directed jobs push expected reads, accumulator
// strobes, results and done pulses with their cycles; a negedge monitor pops and compares.
module tb_pe_mac_ctrl;

   localparam int P = 3;

   typedef struct {
      int cyc;
      int a;
      int b;
   } ev_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] vec_len;
   logic [7:0] out_num;
   logic [9:0] nram_base;
   logic [9:0] wram_base;
   logic       busy;
   logic       done;
   logic       nram_rd_en;
   logic [9:0] nram_addr;
   logic       wram_rd_en;
   logic [9:0] wram_addr;
   logic       acc_en;
   logic       acc_clr;
   logic       result_vld;
   logic       result_rdy;
   logic [7:0] result_idx;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;
   int   zero_cyc = -1;
   int   rise_cyc = -1;
   logic prev_vld = 1'b0;
   logic prev_hold = 1'b0;
   logic [7:0] held_idx = '0;

   ev_t rd_q[$];
   ev_t acc_q[$];
   ev_t res_q[$];
   ev_t done_q[$];

   pe_mac_ctrl #(
      .ADDR_W   (10),
      .LEN_W    (8),
      .PIPE_LAT (P)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .vec_len    (vec_len),
      .out_num    (out_num),
      .nram_base  (nram_base),
      .wram_base  (wram_base),
      .busy       (busy),
      .done       (done),
      .nram_rd_en (nram_rd_en),
      .nram_addr  (nram_addr),
      .wram_rd_en (wram_rd_en),
      .wram_addr  (wram_addr),
      .acc_en     (acc_en),
      .acc_clr    (acc_clr),
      .result_vld (result_vld),
      .result_rdy (result_rdy),
      .result_idx (result_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      n_cmp++;
      if (actual != expected) begin
         n_err++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
      end
   endtask

   // Issues one job and precomputes every event it should produce. Optional extras:
   // a ready stall window, spurious starts while busy and in FIN, and a mid-job reset.
   task automatic applyStimulus(input int vl, input int on, input int nb, input int wb,
                                input int stall_lo, input int stall_n,
                                input int ign_busy, input bit ign_fin, input int rst_at);
      int T, t, rise, hand, fin, limit;
      logic [9:0] wa;
      @(posedge clk); #1;
      T          = cyc;
      start      = 1'b1;
      vec_len    = vl[7:0];
      out_num    = on[7:0];
      nram_base  = nb[9:0];
      wram_base  = wb[9:0];
      result_rdy = 1'b1;
      limit = (rst_at > 0) ? T + rst_at : 32'h3fff_ffff;
      if (vl == 0 || on == 0) begin
         fin = T + 1;
      end else begin
         t  = T + 1;
         wa = wb[9:0];
         for (int o = 0; o < on; o++) begin
            for (int k = 0; k < vl; k++) begin
               if (t + k <= limit) rd_q.push_back('{t + k, (nb + k) & 1023, int'(wa)});
               if (t + k + P <= limit) acc_q.push_back('{t + k + P, (k == 0) ? 1 : 0, 0});
               wa = wa + 10'd1;
            end
            rise = t + vl + P;
            hand = rise;
            while (stall_n > 0 && hand >= T + stall_lo && hand < T + stall_lo + stall_n) hand++;
            if (hand <= limit) res_q.push_back('{hand, o, rise});
            t = hand + 1;
         end
         fin = t;
      end
      if (fin <= limit) done_q.push_back('{fin, 0, 0});
      busy_lo = T + 1;
      busy_hi = fin - 1;
      if (rst_at > 0) begin
         fin      = T + rst_at + 1;
         busy_hi  = T + rst_at;
         zero_cyc = fin;
      end
      while (cyc < fin) begin
         @(posedge clk); #1;
         start      = 1'b0;
         result_rdy = !(stall_n > 0 && cyc >= T + stall_lo && cyc < T + stall_lo + stall_n);
         if (ign_busy > 0 && cyc == T + ign_busy) begin
            start     = 1'b1;
            vec_len   = 8'd7;
            out_num   = 8'd2;
            nram_base = 10'h155;
            wram_base = 10'h2AA;
         end
         if (rst_at > 0 && cyc == T + rst_at) rst = 1'b1;
         if (rst_at > 0 && cyc == T + rst_at + 1) rst = 1'b0;
         if (ign_fin && cyc == fin) begin
            start     = 1'b1;
            vec_len   = 8'd5;
            out_num   = 8'd1;
            nram_base = 10'h0AA;
            wram_base = 10'h011;
         end
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   // Monitor: every DUT event is matched against the oldest expected entry of its kind.
   always @(negedge clk) begin
      ev_t e;
      if (nram_rd_en || wram_rd_en) begin
         checkOutput("rd_en_pair", wram_rd_en, nram_rd_en);
         checkOutput("rd_expected", rd_q.size() > 0, 1);
         if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            checkOutput("rd_cycle", cyc, e.cyc);
            checkOutput("nram_addr", nram_addr, e.a);
            checkOutput("wram_addr", wram_addr, e.b);
         end
      end
      if (acc_en) begin
         checkOutput("acc_expected", acc_q.size() > 0, 1);
         if (acc_q.size() > 0) begin
            e = acc_q.pop_front();
            checkOutput("acc_cycle", cyc, e.cyc);
            checkOutput("acc_clr", acc_clr, e.a);
         end
      end else if (acc_clr) begin
         checkOutput("acc_clr_alone", acc_clr, 0);
      end
      if (result_vld && !prev_vld) rise_cyc = cyc;
      if (prev_hold) begin
         checkOutput("vld_held", result_vld, 1);
         checkOutput("idx_held", result_idx, held_idx);
      end
      if (result_vld && result_rdy) begin
         checkOutput("res_expected", res_q.size() > 0, 1);
         if (res_q.size() > 0) begin
            e = res_q.pop_front();
            checkOutput("res_cycle", cyc, e.cyc);
            checkOutput("result_idx", result_idx, e.a);
            checkOutput("vld_rise_cycle", rise_cyc, e.b);
         end
      end
      prev_hold = result_vld && !result_rdy;
      held_idx  = result_idx;
      prev_vld  = result_vld;
      if (done) begin
         checkOutput("done_expected", done_q.size() > 0, 1);
         if (done_q.size() > 0) begin
            e = done_q.pop_front();
            checkOutput("done_cycle", cyc, e.cyc);
         end
      end
      checkOutput("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (cyc == zero_cyc) begin
         checkOutput("outputs_after_rst",
                     {busy, done, nram_rd_en, nram_addr, wram_rd_en, wram_addr,
                      acc_en, acc_clr, result_vld, result_idx}, 0);
      end
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      vec_len    = '0;
      out_num    = '0;
      nram_base  = '0;
      wram_base  = '0;
      result_rdy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state",
                  {busy, done, nram_rd_en, nram_addr, wram_rd_en, wram_addr,
                   acc_en, acc_clr, result_vld, result_idx}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      idleCycles(2);

      $display("[TB] basic job vec_len=4 out_num=1");
      applyStimulus(4, 1, 'h10, 'h20, 0, 0, 0, 1'b0, 0);
      idleCycles(3);

      $display("[TB] three dot products vec_len=3");
      applyStimulus(3, 3, 0, 0, 0, 0, 0, 1'b0, 0);
      idleCycles(2);

      $display("[TB] write-back stall of 5 cycles");
      applyStimulus(2, 2, 5, 9, 6, 5, 0, 1'b0, 0);
      idleCycles(2);

      $display("[TB] empty jobs");
      applyStimulus(0, 3, 'h40, 'h50, 0, 0, 0, 1'b0, 0);
      applyStimulus(3, 0, 'h40, 'h50, 0, 0, 0, 1'b0, 0);
      idleCycles(2);

      $display("[TB] reset during drain, then clean rerun");
      applyStimulus(4, 1, 'h10, 'h20, 0, 0, 0, 1'b0, 6);
      applyStimulus(4, 1, 'h10, 'h20, 0, 0, 0, 1'b0, 0);
      idleCycles(2);

      $display("[TB] ignored starts and address wrap");
      applyStimulus(6, 1, 'h3FE, 1020, 0, 0, 2, 1'b1, 0);
      applyStimulus(4, 2, 'h10, 'h20, 0, 0, 0, 1'b0, 0);
      idleCycles(2);

      $display("[TB] maximum vec_len");
      applyStimulus(255, 2, 'h300, 'h100, 0, 0, 0, 1'b0, 0);
      idleCycles(6);

      checkOutput("rd_q_drained", rd_q.size(), 0);
      checkOutput("acc_q_drained", acc_q.size(), 0);
      checkOutput("res_q_drained", res_q.size(), 0);
      checkOutput("done_q_drained", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
